// File: rtl/fpu16_issue_ctrl.sv
// fpu16_issue_ctrl: round-robin issue/response sequencer in front of the shared FPU16 datapath
module fpu16_issue_ctrl #(
    parameter int         FPU_LATENCY = 1,
    parameter logic [3:0] OP_MASK     = 4'b0011
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic [15:0] fpu_in1,
    output logic [15:0] fpu_in2,
    output logic [1:0]  fpu_op,
    input  logic [15:0] fpu_out,
    input  logic [3:0]  fpu_cc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [15:0] resp_data,
    output logic [3:0]  resp_cc,
    output logic        resp_err,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] fpu_in1_q, fpu_in1_d, fpu_in2_q, fpu_in2_d, resp_data_q, resp_data_d;
    logic [1:0]  fpu_op_q, fpu_op_d;
    logic        resp_id_q, resp_id_d, resp_err_q, resp_err_d;
    logic [3:0]  resp_cc_q, resp_cc_d;
    logic        grant0, grant1, accept;
    logic [1:0]  sel_op;
    logic [15:0] sel_a, sel_b;
    // Requester 1 wins only when alone or when requester 0 had the previous grant
    assign grant1     = req1_valid && (!req0_valid || !last_grant_q);
    assign grant0     = req0_valid && !grant1;
    assign req0_ready = !reset && state_q == IDLE && grant0;
    assign req1_ready = !reset && state_q == IDLE && grant1;
    assign accept     = req0_ready || req1_ready;
    assign sel_op     = grant1 ? req1_op : req0_op;
    assign sel_a      = grant1 ? req1_a : req0_a;
    assign sel_b      = grant1 ? req1_b : req0_b;
    assign fpu_in1    = fpu_in1_q;
    assign fpu_in2    = fpu_in2_q;
    assign fpu_op     = fpu_op_q;
    assign resp_valid = state_q == RESP;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign resp_cc    = resp_cc_q;
    assign resp_err   = resp_err_q;
    assign busy       = state_q != IDLE;
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        fpu_in1_d    = fpu_in1_q;
        fpu_in2_d    = fpu_in2_q;
        fpu_op_d     = fpu_op_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        resp_cc_d    = resp_cc_q;
        resp_err_d   = resp_err_q;
        if (state_q == IDLE && accept) begin
            last_grant_d = grant1;
            resp_id_d    = grant1;
            cnt_d        = 4'(FPU_LATENCY - 1);
            if (OP_MASK[sel_op]) begin
                fpu_in1_d = sel_a;
                fpu_in2_d = sel_b;
                fpu_op_d  = sel_op;
                state_d   = EXEC;
            end else begin
                resp_data_d = 16'h7E00;
                resp_cc_d   = 4'd0;
                resp_err_d  = 1'b1;
                state_d     = RESP;
            end
        end else if (state_q == EXEC) begin
            if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                resp_data_d = fpu_out;
                resp_cc_d   = fpu_cc;
                resp_err_d  = 1'b0;
                state_d     = RESP;
            end
        end else if (state_q == RESP && resp_ready) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
            fpu_in1_q    <= 16'd0;
            fpu_in2_q    <= 16'd0;
            fpu_op_q     <= 2'd0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= 16'd0;
            resp_cc_q    <= 4'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            fpu_in1_q    <= fpu_in1_d;
            fpu_in2_q    <= fpu_in2_d;
            fpu_op_q     <= fpu_op_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            resp_cc_q    <= resp_cc_d;
            resp_err_q   <= resp_err_d;
        end
    end
endmodule

// File: tb/tb_fpu16_issue_ctrl.sv
// tb_fpu16_issue_ctrl: two DUTs (latency 1 and 3) checked every cycle against a transaction-timestamp model
module tb_fpu16_issue_ctrl;
    localparam logic [3:0] OPM = 4'b0011;
    logic clock = 1'b0;
    int   errs = 0;
    int   checks = 0;
    always #5 clock = ~clock;

    task automatic chk(input int inst, input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL lat%0d %s: got %h expected %h at %0t", inst, name, act, exp, $time);
        end
    endtask

    // Stand-in FPU: returns {cc, result}; the 3C00+4000 case gives the real FP16 sum 4200
    function automatic logic [19:0] fpu_model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        logic [15:0] r;
        logic [3:0]  c;
        r = (a == 16'h3C00 && b == 16'h4000 && op == 2'd0) ? 16'h4200 : (a + b) ^ {14'd0, op};
        c = (a == 16'h3C00 && b == 16'h4000 && op == 2'd0) ? 4'd0 : a[3:0] ^ b[15:12] ^ {2'd0, op};
        return {c, r};
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g
        localparam int LAT = (k == 0) ? 1 : 3;
        logic        rst, r0v, r1v, rr, started, done;
        logic [1:0]  r0op, r1op, fop;
        logic [15:0] r0a, r0b, r1a, r1b, fin1, fin2, fout, rdata;
        logic [3:0]  fcc, rcc;
        logic        r0rdy, r1rdy, rvalid, rid, rerr, bsy;
        assign {fcc, fout} = fpu_model(fin1, fin2, fop);

        fpu16_issue_ctrl #(.FPU_LATENCY(LAT), .OP_MASK(OPM)) dut (
            .clock(clock), .reset(rst),
            .req0_valid(r0v), .req0_ready(r0rdy), .req0_op(r0op), .req0_a(r0a), .req0_b(r0b),
            .req1_valid(r1v), .req1_ready(r1rdy), .req1_op(r1op), .req1_a(r1a), .req1_b(r1b),
            .fpu_in1(fin1), .fpu_in2(fin2), .fpu_op(fop), .fpu_out(fout), .fpu_cc(fcc),
            .resp_valid(rvalid), .resp_ready(rr), .resp_id(rid), .resp_data(rdata),
            .resp_cc(rcc), .resp_err(rerr), .busy(bsy)
        );

        // Model: one outstanding transaction with the cycle its response becomes visible
        int          cyc = 0;
        int          t_rv;
        logic        out = 1'b0, last = 1'b1, m_id, m_err;
        logic [15:0] m_in1 = 16'd0, m_in2 = 16'd0, m_data;
        logic [1:0]  m_op = 2'd0;
        logic [3:0]  m_cc;
        always @(posedge clock) cyc <= cyc + 1;

        always @(negedge clock) begin
            logic        e0, e1, erv, sup;
            logic [1:0]  op;
            logic [15:0] a, b;
            logic [19:0] f;
            if (started) begin
                e1  = !rst && !out && r1v && (!r0v || !last);
                e0  = !rst && !out && r0v && !e1;
                erv = out && cyc >= t_rv;
                chk(k, "req0_ready", r0rdy, e0);
                chk(k, "req1_ready", r1rdy, e1);
                chk(k, "ready_excl", r0rdy & r1rdy, 0);
                chk(k, "busy", bsy, out);
                chk(k, "resp_valid", rvalid, erv);
                chk(k, "fpu_in1", fin1, m_in1);
                chk(k, "fpu_in2", fin2, m_in2);
                chk(k, "fpu_op", fop, m_op);
                if (erv) begin
                    chk(k, "resp_id", rid, m_id);
                    chk(k, "resp_data", rdata, m_data);
                    chk(k, "resp_cc", rcc, m_cc);
                    chk(k, "resp_err", rerr, m_err);
                end
                if (rst) begin
                    out = 0; last = 1; m_in1 = 0; m_in2 = 0; m_op = 0;
                end else if (erv && rr) begin
                    out = 0;
                end else if (e0 || e1) begin
                    op = e1 ? r1op : r0op;
                    a  = e1 ? r1a : r0a;
                    b  = e1 ? r1b : r0b;
                    sup = OPM[op];
                    f = fpu_model(a, b, op);
                    out = 1; last = e1; m_id = e1;
                    t_rv = cyc + (sup ? LAT + 1 : 1);
                    m_data = sup ? f[15:0] : 16'h7E00;
                    m_cc   = sup ? f[19:16] : 4'd0;
                    m_err  = !sup;
                    if (sup) begin
                        m_in1 = a; m_in2 = b; m_op = op;
                    end
                end
            end
        end

        task automatic step();
            @(posedge clock);
            #1;
        endtask

        task automatic wait_acc(input logic which);
            logic hit;
            hit = 0;
            for (int i = 0; i < 20 && !hit; i++) begin
                @(negedge clock);
                hit = which ? r1rdy : r0rdy;
            end
            if (!hit) chk(k, "accept_timeout", 0, 1);
            step();
        endtask

        initial begin
            logic a0, a1;
            started = 0; done = 0;
            rst = 1; rr = 1;
            r0v = 1; r0op = 2'd0; r0a = 16'h3C00; r0b = 16'h4000;
            r1v = 0; r1op = 2'd0; r1a = 16'h0; r1b = 16'h0;
            for (int i = 0; i < 2; i++) begin
                step();
                started = 1;
                chk(k, "rst_busy", bsy, 0);
                chk(k, "rst_resp_valid", rvalid, 0);
                chk(k, "rst_ready0", r0rdy, 0);
                chk(k, "rst_ready1", r1rdy, 0);
                chk(k, "rst_fpu_in1", fin1, 0);
                chk(k, "rst_fpu_in2", fin2, 0);
            end
            rst = 0;
            wait_acc(0);
            r0v = 0;
            chk(k, "add_fpu_in1", fin1, 16'h3C00);
            chk(k, "add_fpu_in2", fin2, 16'h4000);
            repeat (LAT - 1) step();
            chk(k, "add_not_yet", rvalid, 0);
            step();
            chk(k, "add_resp_valid", rvalid, 1);
            chk(k, "add_data", rdata, 16'h4200);
            chk(k, "add_id", rid, 0);
            chk(k, "add_err", rerr, 0);
            step();
            r0v = 1; r0op = 2'd2; r0a = 16'h1234; r0b = 16'h5678;
            wait_acc(0);
            r0v = 0;
            chk(k, "mul_resp_valid", rvalid, 1);
            chk(k, "mul_data", rdata, 16'h7E00);
            chk(k, "mul_err", rerr, 1);
            chk(k, "mul_fpu_op", fop, 0);
            step();
            r1v = 1; r1op = 2'd1; r1a = 16'h4400; r1b = 16'h3C00;
            r0v = 1; r0op = 2'd0; r0a = 16'h0101; r0b = 16'h2020;
            rr = 0;
            wait_acc(1);
            r1v = 0;
            repeat (LAT) step();
            for (int i = 0; i < 5; i++) begin
                chk(k, "bp_valid", rvalid, 1);
                chk(k, "bp_id", rid, 1);
                chk(k, "bp_ready0", r0rdy, 0);
                chk(k, "bp_busy", bsy, 1);
                step();
            end
            rr = 1;
            step();
            chk(k, "bp_idle", bsy, 0);
            chk(k, "bp_next_ready0", r0rdy, 1);
            step();
            rst = 1;
            step();
            rst = 0; r0v = 0;
            chk(k, "midrst_resp_valid", rvalid, 0);
            chk(k, "midrst_busy", bsy, 0);
            repeat (4) step();
            for (int i = 0; i < 400; i++) begin
                @(negedge clock);
                a0 = r0rdy; a1 = r1rdy;
                step();
                if (!r0v || a0) begin
                    r0v = $urandom_range(0, 2) != 0; r0op = 2'($urandom); r0a = 16'($urandom); r0b = 16'($urandom);
                end
                if (!r1v || a1) begin
                    r1v = $urandom_range(0, 2) != 0; r1op = 2'($urandom); r1a = 16'($urandom); r1b = 16'($urandom);
                end
                rr  = $urandom_range(0, 3) != 0;
                rst = $urandom_range(0, 99) == 0;
            end
            rst = 0;
            step();
            done = 1;
        end
    end

    initial begin
        wait (g[0].done && g[1].done);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
